// File: rtl/dot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dot_pkg
//  Purpose  : Shared sizing constants, element/vector types and the FSM
//             state encoding for the dot_stream_sequencer slice.
//  Ports    : none (package)
//  Config   : DOT_SEQ_PIPE_EN selects the pipelined lane-sum build; the
//             DRAIN state is only entered in that build.
//  Revision : 1.0 - initial release
// ============================================================================
package dot_pkg;

  localparam int LANES      = 8;
  localparam int ELEM_W     = 8;
  localparam int BEATS_W    = 8;
  localparam int PROD_W     = 2 * ELEM_W;
  localparam int LANE_SUM_W = PROD_W + $clog2(LANES);
  // Wide enough that (2^BEATS_W - 1) beats of maximal lane sums never overflow.
  localparam int ACC_W      = LANE_SUM_W + BEATS_W;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t             lane_vec_t [LANES-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } dot_seq_state_e;

endpackage : dot_pkg
`default_nettype wire

// File: rtl/dot_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dot_stream_sequencer_if
//  Purpose  : Groups the command, operand-stream and result handshakes of the
//             dot-product sequencer, plus its busy flag.
//  Signals  : cmd_valid/cmd_ready/cmd_beats  - job command
//             in_valid/in_ready/in_a/in_b    - operand beats (LANES elements)
//             out_valid/out_ready/out_sum    - dot-product result
//             busy                           - sequencer not idle
//  Modports : slave  - the sequencer side
//             master - the job source / result consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface dot_stream_sequencer_if;
  import dot_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [BEATS_W-1:0] cmd_beats;
  logic               in_valid;
  logic               in_ready;
  lane_vec_t          in_a;
  lane_vec_t          in_b;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               busy;

  modport slave (
    input  cmd_valid, cmd_beats, in_valid, in_a, in_b, out_ready,
    output cmd_ready, in_ready, out_valid, out_sum, busy
  );

  modport master (
    output cmd_valid, cmd_beats, in_valid, in_a, in_b, out_ready,
    input  cmd_ready, in_ready, out_valid, out_sum, busy
  );

endinterface : dot_stream_sequencer_if
`default_nettype wire

// File: rtl/dot_lane_sum.sv
`default_nettype none
// ============================================================================
//  Module   : dot_lane_sum
//  Purpose  : LANES unsigned multipliers followed by an adder reduction,
//             producing sum_i a[i]*b[i] for one operand beat.
//  Ports    : clk, reset_n  - only present when DOT_SEQ_PIPE_EN is defined
//             i_a, i_b      - operand vectors
//             i_vld         - beat is being consumed this cycle
//             o_sum         - lane sum (LANE_SUM_W bits)
//             o_vld         - o_sum carries a consumed beat
//  Config   : DOT_SEQ_PIPE_EN defined  -> o_sum/o_vld registered (1 stage)
//             DOT_SEQ_PIPE_EN undefined -> purely combinational
//  Revision : 1.0 - initial release
// ============================================================================
module dot_lane_sum
  import dot_pkg::*;
(
`ifdef DOT_SEQ_PIPE_EN
  input  logic                  clk,
  input  logic                  reset_n,
`endif
  input  lane_vec_t             i_a,
  input  lane_vec_t             i_b,
  input  logic                  i_vld,
  output logic [LANE_SUM_W-1:0] o_sum,
  output logic                  o_vld
);

  logic [PROD_W-1:0]     w_prod [LANES-1:0];
  logic [LANE_SUM_W-1:0] w_sum;

  // Operands are widened before multiplying so the product keeps all bits.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = PROD_W'(i_a[i]) * PROD_W'(i_b[i]);
      w_sum     = w_sum + LANE_SUM_W'(w_prod[i]);
    end
  end

`ifdef DOT_SEQ_PIPE_EN
  logic [LANE_SUM_W-1:0] r_sum;
  logic                  r_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
      r_vld <= 1'b0;
    end else begin
      r_sum <= w_sum;
      r_vld <= i_vld;
    end
  end

  assign o_sum = r_sum;
  assign o_vld = r_vld;
`else
  assign o_sum = w_sum;
  assign o_vld = i_vld;
`endif

endmodule : dot_lane_sum
`default_nettype wire

// File: rtl/dot_stream_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dot_stream_sequencer
//  Purpose  : Runs a multi-beat unsigned dot product: accepts a job command
//             carrying the beat count, accumulates the lane sum of every
//             accepted operand beat and returns the total over valid/ready.
//  Ports    : clk      - clock, rising edge
//             reset_n  - asynchronous active-low reset
//             bus      - dot_stream_sequencer_if.slave (cmd/in/out + busy)
//  Config   : DOT_SEQ_PIPE_EN - registers the lane sum and adds a DRAIN
//             state; results identical, result latency one cycle longer.
//  Revision : 1.0 - initial release
// ============================================================================
module dot_stream_sequencer
  import dot_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  dot_stream_sequencer_if.slave  bus
);

  dot_seq_state_e        r_state;
  dot_seq_state_e        w_state_next;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      w_acc_next;
  logic [BEATS_W-1:0]    r_remaining;
  logic [BEATS_W-1:0]    w_remaining_next;
  logic                  r_out_valid;
  logic [ACC_W-1:0]      r_out_sum;

  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [LANE_SUM_W-1:0] w_lane_sum;
  logic                  w_lane_vld;

  // Handshakes depend only on registered state, so there is no combinational
  // path from a ready back into the lane-sum datapath.
  assign w_in_hs  = bus.in_valid && (r_state == STREAM);
  assign w_out_hs = r_out_valid && bus.out_ready;

  dot_lane_sum u_lane_sum (
`ifdef DOT_SEQ_PIPE_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .i_vld   (w_in_hs),
    .o_sum   (w_lane_sum),
    .o_vld   (w_lane_vld)
  );

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_remaining_next = r_remaining;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          w_acc_next       = '0;
          w_remaining_next = bus.cmd_beats;
          w_state_next     = (bus.cmd_beats == '0) ? RESULT : STREAM;
        end
      end
      STREAM: begin
        // w_lane_vld is the current beat (combinational build) or the
        // previous beat (pipelined build); either way each beat adds once.
        if (w_lane_vld) begin
          w_acc_next = r_acc + ACC_W'(w_lane_sum);
        end
        if (w_in_hs) begin
          w_remaining_next = r_remaining - BEATS_W'(1);
          if (r_remaining == BEATS_W'(1)) begin
`ifdef DOT_SEQ_PIPE_EN
            w_state_next = DRAIN;
`else
            w_state_next = RESULT;
`endif
          end
        end
      end
`ifdef DOT_SEQ_PIPE_EN
      DRAIN: begin
        // Fold in the last beat still sitting in the lane-sum register.
        if (w_lane_vld) begin
          w_acc_next = r_acc + ACC_W'(w_lane_sum);
        end
        w_state_next = RESULT;
      end
`endif
      RESULT: begin
        if (w_out_hs) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_remaining <= w_remaining_next;
    end
  end

  // The output register captures the settled accumulator on the first RESULT
  // cycle and holds it until the consumer takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
    end else if ((r_state == RESULT) && !r_out_valid) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= r_acc;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.in_ready  = (r_state == STREAM);
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.busy      = (r_state != IDLE);

endmodule : dot_stream_sequencer
`default_nettype wire
